cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

Multicycle control unit for the 16-bit simple CPU. It sequences fetch, decode and execute, and drives the enable and select lines of the datapath `register` instances (PC, IR, MAR, ACC), the ALU operation code and the memory read/write strobes. It consumes the IR contents and the ACC zero flag, and handshakes with memory through `mem_ready`.

## Interface
- `ADDR_W`, default 12: address field width, taken from `ir[ADDR_W-1:0]`.
- `clk`  in  1: single system clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `ir`  in  16: current IR register output; `ir[15:12]` is the opcode, `ir[11:0]` the address.
- `acc_zero`  in  1: high when ACC == 16'h0000.
- `mem_ready`  in  1: memory has completed the current read or write this cycle.
- `pc_en`  out  1: PC register enable.
- `pc_sel`  out  1: PC source; 0 = PC+1, 1 = `ir[11:0]`.
- `ir_en`  out  1: IR register enable.
- `mar_en`  out  1: MAR register enable.
- `mar_sel`  out  1: MAR source; 0 = PC, 1 = `ir[11:0]`.
- `acc_en`  out  1: ACC register enable.
- `alu_op`  out  3: 0 = PASS (memory data), 1 = ADD, 2 = SUB, 3 = AND.
- `mem_rd`  out  1: memory read strobe, held until `mem_ready`.
- `mem_wr`  out  1: memory write strobe (ACC to mem[MAR]), held until `mem_ready`.
- `halted`  out  1: high in HALT.
- `illegal`  out  1: one-cycle pulse in DECODE when the opcode is undefined.

## Operation
- Opcodes:
  - 0 NOP
  - 1 LOAD
  - 2 STORE
  - 3 ADD
  - 4 SUB
  - 5 AND
  - 6 JMP
  - 7 JZ
  - F HALT
  - 8–E are illegal: treated as NOP with an `illegal` pulse.
- States: RESET, FETCH, READ_IR, DECODE, MEM_RD, MEM_WR, HALT.
- Outputs are combinational from the state, plus `mem_ready` and `ir` where noted. Any output not listed for a state is 0. `alu_op` defaults to 0.
- RESET: all outputs 0. Goes to FETCH on the next clock.
- FETCH: `mar_en`=1, `mar_sel`=0. Goes to READ_IR.
- READ_IR: `mem_rd`=1.
  - If `mem_ready`: `ir_en`=1, `pc_en`=1, `pc_sel`=0, then DECODE.
  - Otherwise stay in READ_IR.
- DECODE, by opcode:
  - LOAD, ADD, SUB, AND: `mar_en`=1, `mar_sel`=1, then MEM_RD.
  - STORE: `mar_en`=1, `mar_sel`=1, then MEM_WR.
  - JMP, or JZ with `acc_zero`=1: `pc_en`=1, `pc_sel`=1, then FETCH.
  - JZ with `acc_zero`=0, NOP, illegal: go to FETCH.
  - HALT: go to HALT.
- MEM_RD: `mem_rd`=1 and `alu_op` set per opcode.
  - If `mem_ready`: `acc_en`=1, then FETCH.
  - Otherwise stay.
- MEM_WR: `mem_wr`=1.
  - If `mem_ready`: go to FETCH.
  - Otherwise stay.
- HALT: `halted`=1. Absorbing; only `rst` leaves it.
- An opcode is decoded from `ir` only in DECODE and MEM_RD. The IR is stable in those states because `ir_en` is 0.

## Timing
- Reset: asserting `rst` forces state RESET immediately and asynchronously, from any state, including mid memory wait. All outputs go to 0 in the same delta.
- First FETCH occurs on the first rising edge after `rst` is released.
- Instruction cycle counts with `mem_ready` tied high:
  - NOP, JMP, JZ, illegal: 3 cycles.
  - LOAD, ADD, SUB, AND, STORE: 4 cycles.
- Each cycle of `mem_ready`=0 in READ_IR, MEM_RD or MEM_WR adds one cycle. Strobes stay asserted and no enable fires while waiting.
- Register writes occur on the edge that ends the state in which the enable is high. PC+1 and IR load share the same edge.
- `mem_ready` is ignored outside the READ_IR, MEM_RD and MEM_WR states.
- PC wrap-around (0xFFF+1 → 0x000) is the datapath's concern; the controller does not detect it.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (OP_NOP … OP_HALT);
  - `alu_op` codes;
  - the state encoding (one-hot or binary; the package constant decides).
- No sub-module. The opcode decode is a case statement inside `cpu_ctrl`.

## Test plan
- Reset release with `mem_ready`=1: RESET → FETCH with `mar_en`=1, `mar_sel`=0 on the first edge; all outputs were 0 during reset.
- `ir`=16'h1005 (LOAD 5), `mem_ready`=1: the instruction takes 4 cycles. Check `mar_sel`=1 in DECODE, then MEM_RD with `acc_en`=1 and `alu_op`=0.
- `ir`=16'h2010 (STORE), with `mem_ready` held low 3 cycles in MEM_WR: `mem_wr` stays high 4 cycles and FETCH follows the ready cycle.
- `ir`=16'h7020 (JZ): with `acc_zero`=1, DECODE gives `pc_en`=1 and `pc_sel`=1; with `acc_zero`=0, `pc_en`=0. Both go directly to FETCH.
- `ir`=16'h9000: one-cycle `illegal` pulse, no enables, back to FETCH. `ir`=16'hF000: `halted` stays high for 20+ cycles, ignoring `mem_ready`.
- `rst` asserted while in MEM_RD with `mem_rd`=1: all outputs drop to 0 immediately and fetch resumes after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the simple 16-bit CPU: opcodes, ALU codes and the
// control state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;

  // Binary state encoding; widen STATE_W and the enum for one-hot.
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_READ_IR = 3'd2,
    S_DECODE  = 3'd3,
    S_MEM_RD  = 3'd4,
    S_MEM_WR  = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  function automatic logic [2:0] alu_for_op(input logic [3:0] op);
    logic [2:0] alu;
    case (op)
      OP_ADD:  alu = ALU_ADD;
      OP_SUB:  alu = ALU_SUB;
      OP_AND:  alu = ALU_AND;
      default: alu = ALU_PASS;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/cpu_ctrl.sv
// Multicycle control unit: sequences fetch/decode/execute and drives the
// datapath register enables, selects, ALU code and memory strobes.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        acc_zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        ir_en,
  output logic        mar_en,
  output logic        mar_sel,
  output logic        acc_en,
  output logic [2:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        illegal
);

  state_t     state;
  state_t     next_state;
  logic [3:0] opcode;
  logic       unused_addr;

  assign opcode = ir[15:12];
  // The address field feeds the datapath directly, not the controller.
  assign unused_addr = ^ir[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RESET;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RESET:   next_state = S_FETCH;
      S_FETCH:   next_state = S_READ_IR;
      S_READ_IR: if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND: next_state = S_MEM_RD;
          OP_STORE:                        next_state = S_MEM_WR;
          OP_HALT:                         next_state = S_HALT;
          default:                         next_state = S_FETCH;
        endcase
      end
      S_MEM_RD:  if (mem_ready) next_state = S_FETCH;
      S_MEM_WR:  if (mem_ready) next_state = S_FETCH;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_RESET;
    endcase
  end

  always_comb begin
    pc_en   = 1'b0;
    pc_sel  = 1'b0;
    ir_en   = 1'b0;
    mar_en  = 1'b0;
    mar_sel = 1'b0;
    acc_en  = 1'b0;
    alu_op  = ALU_PASS;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
    case (state)
      S_FETCH: mar_en = 1'b1;
      S_READ_IR: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_en = 1'b1;
          pc_en = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_STORE: begin
            mar_en  = 1'b1;
            mar_sel = 1'b1;
          end
          OP_JMP: begin
            pc_en  = 1'b1;
            pc_sel = 1'b1;
          end
          OP_JZ: begin
            pc_en  = acc_zero;
            pc_sel = acc_zero;
          end
          OP_NOP, OP_HALT: ;
          default: illegal = 1'b1;
        endcase
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        alu_op = alu_for_op(opcode);
        acc_en = mem_ready;
      end
      S_MEM_WR: mem_wr = 1'b1;
      S_HALT:   halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed testbench for cpu_ctrl: walks instruction sequences and compares
// the full control output vector against hand-computed values each cycle.
module tb_cpu_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] ir;
  logic        acc_zero;
  logic        mem_ready;
  logic        pc_en, pc_sel, ir_en, mar_en, mar_sel, acc_en;
  logic [2:0]  alu_op;
  logic        mem_rd, mem_wr, halted, illegal;
  logic [12:0] obs;

  int total = 0;
  int bad   = 0;

  cpu_ctrl #(.ADDR_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .ir        (ir),
    .acc_zero  (acc_zero),
    .mem_ready (mem_ready),
    .pc_en     (pc_en),
    .pc_sel    (pc_sel),
    .ir_en     (ir_en),
    .mar_en    (mar_en),
    .mar_sel   (mar_sel),
    .acc_en    (acc_en),
    .alu_op    (alu_op),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .halted    (halted),
    .illegal   (illegal)
  );

  assign obs = {pc_en, pc_sel, ir_en, mar_en, mar_sel, acc_en, alu_op,
                mem_rd, mem_wr, halted, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector order: pc_en pc_sel ir_en mar_en mar_sel acc_en alu rd wr halt ill
  function automatic logic [12:0] o(input logic pe, ps, ie, me, ms, ae,
                                    input logic [2:0] alu,
                                    input logic rd, wr, hl, il);
    return {pe, ps, ie, me, ms, ae, alu, rd, wr, hl, il};
  endfunction

  task automatic checkOutput(input string tag, input logic [12:0] got, input logic [12:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%b want=%b", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] instr, input logic az, input logic rdy);
    ir        = instr;
    acc_zero  = az;
    mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // From FETCH, run FETCH and a ready READ_IR; ends in DECODE.
  task automatic fetchInstr(input logic [15:0] instr, input logic az);
    applyStimulus(instr, az, 1'b1);
    checkOutput("fetch", obs, o(0,0,0,1,0,0,3'd0,0,0,0,0));
    tick();
    applyStimulus(instr, az, 1'b1);
    checkOutput("read_ir", obs, o(1,0,1,0,0,0,3'd0,1,0,0,0));
    tick();
  endtask

  // Arithmetic/load instruction with one wait cycle in MEM_RD.
  task automatic memRdInstr(input logic [15:0] instr, input logic [2:0] alu);
    fetchInstr(instr, 1'b0);
    checkOutput("decode_rd", obs, o(0,0,0,1,1,0,3'd0,0,0,0,0));
    tick();
    applyStimulus(instr, 1'b0, 1'b0);
    checkOutput("mem_rd_wait", obs, o(0,0,0,0,0,0,alu,1,0,0,0));
    tick();
    applyStimulus(instr, 1'b0, 1'b1);
    checkOutput("mem_rd_done", obs, o(0,0,0,0,0,1,alu,1,0,0,0));
    tick();
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("reset_outs", obs, '0);
    tick();
    checkOutput("reset_hold", obs, '0);

    rst = 1'b1;
    tick();

    // LOAD 5 with mem_ready high: FETCH, READ_IR, DECODE, MEM_RD, FETCH
    fetchInstr(16'h1005, 1'b0);
    checkOutput("load_decode", obs, o(0,0,0,1,1,0,3'd0,0,0,0,0));
    tick();
    checkOutput("load_mem_rd", obs, o(0,0,0,0,0,1,3'd0,1,0,0,0));
    tick();

    memRdInstr(16'h3007, 3'd1);
    memRdInstr(16'h4008, 3'd2);
    memRdInstr(16'h5009, 3'd3);

    // STORE with three wait cycles and a READ_IR wait first
    applyStimulus(16'h2010, 1'b0, 1'b1);
    checkOutput("st_fetch", obs, o(0,0,0,1,0,0,3'd0,0,0,0,0));
    tick();
    applyStimulus(16'h2010, 1'b0, 1'b0);
    checkOutput("read_ir_wait", obs, o(0,0,0,0,0,0,3'd0,1,0,0,0));
    tick();
    applyStimulus(16'h2010, 1'b0, 1'b1);
    checkOutput("st_read_ir", obs, o(1,0,1,0,0,0,3'd0,1,0,0,0));
    tick();
    checkOutput("st_decode", obs, o(0,0,0,1,1,0,3'd0,0,0,0,0));
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h2010, 1'b0, 1'b0);
      checkOutput("st_wait", obs, o(0,0,0,0,0,0,3'd0,0,1,0,0));
      tick();
    end
    applyStimulus(16'h2010, 1'b0, 1'b1);
    checkOutput("st_done", obs, o(0,0,0,0,0,0,3'd0,0,1,0,0));
    tick();

    fetchInstr(16'h7020, 1'b1);
    checkOutput("jz_taken", obs, o(1,1,0,0,0,0,3'd0,0,0,0,0));
    tick();
    fetchInstr(16'h7020, 1'b0);
    checkOutput("jz_not_taken", obs, '0);
    tick();
    fetchInstr(16'h6123, 1'b0);
    checkOutput("jmp", obs, o(1,1,0,0,0,0,3'd0,0,0,0,0));
    tick();
    fetchInstr(16'h0000, 1'b0);
    checkOutput("nop", obs, '0);
    tick();
    fetchInstr(16'h9000, 1'b0);
    checkOutput("illegal_9", obs, o(0,0,0,0,0,0,3'd0,0,0,0,1));
    tick();
    fetchInstr(16'hE123, 1'b0);
    checkOutput("illegal_e", obs, o(0,0,0,0,0,0,3'd0,0,0,0,1));
    tick();

    fetchInstr(16'hF000, 1'b0);
    checkOutput("halt_decode", obs, '0);
    tick();
    for (int i = 0; i < 22; i++) begin
      applyStimulus(16'hF000, 1'b0, i[0]);
      checkOutput("halted", obs, o(0,0,0,0,0,0,3'd0,0,0,1,0));
      tick();
    end

    rst = 1'b0;
    #1;
    checkOutput("halt_reset", obs, '0);
    tick();
    rst = 1'b1;
    tick();

    // Reset asynchronously in the middle of a MEM_RD wait
    fetchInstr(16'h1005, 1'b0);
    tick();
    applyStimulus(16'h1005, 1'b0, 1'b0);
    checkOutput("pre_rst_mem_rd", obs, o(0,0,0,0,0,0,3'd0,1,0,0,0));
    rst = 1'b0;
    #1;
    checkOutput("async_rst", obs, '0);
    tick();
    applyStimulus(16'h1005, 1'b0, 1'b1);
    checkOutput("rst_held", obs, '0);
    rst = 1'b1;
    tick();
    applyStimulus(16'h1005, 1'b0, 1'b1);
    checkOutput("refetch", obs, o(0,0,0,1,0,0,3'd0,0,0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
